hilo_mul_sequencer: RTL and testbench

- Multi-cycle multiply/HI-LO unit in the EX stage, beside the ALU.
- Executes the HI/LO-class ALUOp codes from the Controller: mult, multu, madd, msub, mul, mthi, mtlo, mfhi, mflo.
- Owns the HI and LO registers and runs a 32-iteration radix-2 shift-add multiplier.
- Asserts Stall to freeze the pipeline while the multiplier is busy.

---
 rtl/hilo_mul_sequencer.sv | 147 ++++++++++++++
 tb/tb_hilo_mul_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_sequencer.sv
// HI/LO multiply unit for the EX stage: 32-step radix-2 shift-add multiplier,
// sign fix-up, and commit into HI/LO or Result, with a pipeline stall request.
module hilo_mul_sequencer #(
    parameter logic [5:0] OP_MADD  = 6'd2,
    parameter logic [5:0] OP_MUL   = 6'd5,
    parameter logic [5:0] OP_MSUB  = 6'd8,
    parameter logic [5:0] OP_MFHI  = 6'd15,
    parameter logic [5:0] OP_MTHI  = 6'd16,
    parameter logic [5:0] OP_MFLO  = 6'd17,
    parameter logic [5:0] OP_MTLO  = 6'd18,
    parameter logic [5:0] OP_MULT  = 6'd19,
    parameter logic [5:0] OP_MULTU = 6'd20
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [5:0]  ALUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    output logic        Stall,
    output logic [31:0] Result,
    output logic        ResultValid,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {IDLE, MULT, SIGN, COMMIT} state_t;

    state_t      state;
    logic [5:0]  op;
    logic        neg;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] prod;
    logic [4:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;
    logic        result_valid;

    logic        is_mc;
    logic        is_valid;
    logic        accept;
    logic        sgn;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] sum;

    always_comb begin
        is_mc    = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU) || (ALUOp == OP_MADD) ||
                   (ALUOp == OP_MSUB) || (ALUOp == OP_MUL);
        is_valid = is_mc || (ALUOp == OP_MTHI) || (ALUOp == OP_MTLO) ||
                   (ALUOp == OP_MFHI) || (ALUOp == OP_MFLO);
        accept   = Start && !Cancel && (state == IDLE) && is_valid;
        sgn      = (ALUOp != OP_MULTU);
        // Negating 0x80000000 wraps back to itself, which is the correct unsigned magnitude.
        mag_a    = (sgn && A[31]) ? (~A + 32'd1) : A;
        mag_b    = (sgn && B[31]) ? (~B + 32'd1) : B;
        sum      = {1'b0, prod[63:32]} + (mplier[0] ? {1'b0, mcand} : 33'd0);
    end

    assign Stall       = Rst && ((state != IDLE) || (Start && is_mc && !Cancel));
    assign Result      = result;
    assign ResultValid = result_valid;
    assign HI          = hi;
    assign LO          = lo;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= IDLE;
            op           <= '0;
            neg          <= 1'b0;
            mcand        <= '0;
            mplier       <= '0;
            prod         <= '0;
            cnt          <= '0;
            hi           <= '0;
            lo           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mc) begin
                            op     <= ALUOp;
                            neg    <= sgn && (A[31] ^ B[31]);
                            mcand  <= mag_a;
                            mplier <= mag_b;
                            prod   <= '0;
                            cnt    <= '0;
                            state  <= MULT;
                        end else if (ALUOp == OP_MTHI) begin
                            hi <= A;
                        end else if (ALUOp == OP_MTLO) begin
                            lo <= A;
                        end else if (ALUOp == OP_MFHI) begin
                            result       <= hi;
                            result_valid <= 1'b1;
                        end else begin
                            result       <= lo;
                            result_valid <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    if (Cancel) begin
                        state <= IDLE;
                    end else begin
                        // Carry out of the upper-half add shifts into bit 63.
                        prod   <= {sum, prod[31:1]};
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= SIGN;
                    end
                end
                SIGN: begin
                    if (Cancel) begin
                        state <= IDLE;
                    end else begin
                        if (neg) prod <= ~prod + 64'd1;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (!Cancel) begin
                        if (op == OP_MADD) begin
                            {hi, lo} <= {hi, lo} + prod;
                        end else if (op == OP_MSUB) begin
                            {hi, lo} <= {hi, lo} - prod;
                        end else if (op == OP_MUL) begin
                            result       <= prod[31:0];
                            result_valid <= 1'b1;
                        end else begin
                            {hi, lo} <= prod;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Randomized bench for hilo_mul_sequencer against a cycle-count arithmetic model of HI/LO.
module tb_hilo_mul_sequencer;

    localparam logic [5:0] OP_MADD  = 6'd2;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_MSUB  = 6'd8;
    localparam logic [5:0] OP_MFHI  = 6'd15;
    localparam logic [5:0] OP_MTHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd17;
    localparam logic [5:0] OP_MTLO  = 6'd18;
    localparam logic [5:0] OP_MULT  = 6'd19;
    localparam logic [5:0] OP_MULTU = 6'd20;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Start = 1'b0;
    logic [5:0]  ALUOp = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Cancel = 1'b0;
    logic        Stall;
    logic [31:0] Result;
    logic        ResultValid;
    logic [31:0] HI;
    logic [31:0] LO;

    hilo_mul_sequencer dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .ALUOp(ALUOp), .A(A), .B(B),
        .Cancel(Cancel), .Stall(Stall), .Result(Result), .ResultValid(ResultValid),
        .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    int stall_cnt = 0;

    // Model: an MC op is a 34-edge countdown followed by one arithmetic commit.
    int          m_rem = 0;
    logic [5:0]  m_op = '0;
    logic [63:0] m_p = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_res = '0;
    logic        m_rv = 1'b0;
    logic        m_acc = 1'b0;

    function automatic logic is_mc(input logic [5:0] o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_MADD) || (o == OP_MSUB) || (o == OP_MUL);
    endfunction

    function automatic logic is_valid(input logic [5:0] o);
        return is_mc(o) || (o == OP_MTHI) || (o == OP_MTLO) || (o == OP_MFHI) || (o == OP_MFLO);
    endfunction

    function automatic logic [63:0] prod64(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o == OP_MULTU) return {32'd0, a} * {32'd0, b};
        return {{32{a[31]}}, a} * {{32{b[31]}}, b};
    endfunction

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_rem <= 0; m_hi <= '0; m_lo <= '0; m_res <= '0; m_rv <= 1'b0; m_acc <= 1'b0;
        end else begin
            m_rv  <= 1'b0;
            m_acc <= 1'b0;
            if (m_rem != 0) begin
                if (Cancel) m_rem <= 0;
                else begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        if (m_op == OP_MADD) {m_hi, m_lo} <= {m_hi, m_lo} + m_p;
                        else if (m_op == OP_MSUB) {m_hi, m_lo} <= {m_hi, m_lo} - m_p;
                        else if (m_op == OP_MUL) begin m_res <= m_p[31:0]; m_rv <= 1'b1; end
                        else {m_hi, m_lo} <= m_p;
                    end
                end
            end else if (Start && !Cancel && is_valid(ALUOp)) begin
                m_acc <= 1'b1;
                if (is_mc(ALUOp)) begin
                    m_rem <= 34; m_op <= ALUOp; m_p <= prod64(ALUOp, A, B);
                end else if (ALUOp == OP_MTHI) m_hi <= A;
                else if (ALUOp == OP_MTLO) m_lo <= A;
                else if (ALUOp == OP_MFHI) begin m_res <= m_hi; m_rv <= 1'b1; end
                else begin m_res <= m_lo; m_rv <= 1'b1; end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] dut_v, input logic [31:0] mod_v,
                             input logic [31:0] lit);
        check({name, "_dut"}, dut_v, lit);
        check({name, "_model"}, mod_v, lit);
    endtask

    always @(negedge Clk) begin
        logic exp_stall;
        exp_stall = Rst && ((m_rem != 0) || (Start && is_mc(ALUOp) && !Cancel));
        if (Stall) stall_cnt++;
        check("stall", {31'd0, Stall}, {31'd0, exp_stall});
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
        check("result", Result, m_res);
        check("result_valid", {31'd0, ResultValid}, {31'd0, m_rv});
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        bit done;
        done = 0;
        Start = 1'b1; ALUOp = o; A = a; B = b;
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            if (m_acc) done = 1;
        end
        if (!done) begin
            bad++; total++;
            $display("FAIL accept_timeout op=%0d", o);
        end
        Start = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = (m_rem == 0);
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            if (m_rem == 0) done = 1;
        end
        if (!done) begin
            bad++; total++;
            $display("FAIL idle_timeout rem=%0d", m_rem);
        end
    endtask

    task automatic cancel_pulse();
        Cancel = 1'b1;
        tick();
        Cancel = 1'b0;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] ops [13];
        ops = '{OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MUL, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO,
                6'd0, 6'd1, 6'd3, 6'd63};
        repeat (3) tick();
        check_lit("reset_hi", HI, m_hi, 32'h0);
        check_lit("reset_stall", {31'd0, Stall}, 32'h0, 32'h0);
        Rst = 1'b1;
        tick();

        stall_cnt = 0;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        check("mult_stall_cycles", stall_cnt, 35);
        check_lit("mult_hi", HI, m_hi, 32'hFFFF_FFFF);
        check_lit("mult_lo", LO, m_lo, 32'hFFFF_FFFE);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        check_lit("multu_hi", HI, m_hi, 32'h1);
        check_lit("multu_lo", LO, m_lo, 32'hFFFF_FFFE);

        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_idle();
        check_lit("minint_hi", HI, m_hi, 32'h4000_0000);
        check_lit("minint_lo", LO, m_lo, 32'h0);
        issue(OP_MULT, 32'h0, 32'h1234_5678);
        wait_idle();
        check_lit("zero_hi", HI, m_hi, 32'h0);

        issue(OP_MTHI, 32'd5, 32'd0);
        issue(OP_MTLO, 32'hA, 32'd0);
        issue(OP_MADD, 32'd3, 32'd4);
        wait_idle();
        check_lit("madd_hi", HI, m_hi, 32'd5);
        check_lit("madd_lo", LO, m_lo, 32'h16);
        issue(OP_MSUB, 32'd3, 32'd4);
        wait_idle();
        check_lit("msub_lo", LO, m_lo, 32'hA);
        issue(OP_MFLO, 32'd0, 32'd0);
        check_lit("mflo_result", Result, m_res, 32'hA);
        check("mflo_rv_pulse", {31'd0, ResultValid}, 32'd1);
        tick();
        check("mflo_rv_drop", {31'd0, ResultValid}, 32'd0);
        issue(OP_MTHI, 32'hFFFF_FFFF, 32'd0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(OP_MADD, 32'd1, 32'd1);
        wait_idle();
        check_lit("madd_wrap_hi", HI, m_hi, 32'h0);
        check_lit("madd_wrap_lo", LO, m_lo, 32'h0);

        issue(OP_MTHI, 32'h1234, 32'd0);
        issue(OP_MUL, 32'h7FFF_FFFF, 32'd2);
        wait_idle();
        check_lit("mul_result", Result, m_res, 32'hFFFF_FFFE);
        check("mul_rv", {31'd0, ResultValid}, 32'd1);
        check_lit("mul_hi_kept", HI, m_hi, 32'h1234);

        issue(OP_MULT, 32'h0001_0000, 32'h0003_0000);
        issue(OP_MFHI, 32'd0, 32'd0);
        check_lit("mfhi_after_mult", Result, m_res, 32'h3);

        issue(OP_MTHI, 32'h1111, 32'd0);
        issue(OP_MTLO, 32'h2222, 32'd0);
        issue(OP_MULT, 32'hFFFF, 32'hFFFF);
        repeat (10) tick();
        cancel_pulse();
        check_lit("cancel_hi", HI, m_hi, 32'h1111);
        check_lit("cancel_lo", LO, m_lo, 32'h2222);
        check("cancel_stall", {31'd0, Stall}, 32'd0);

        issue(OP_MULT, 32'hFFFF, 32'hFFFF);
        repeat (5) tick();
        Rst = 1'b0;
        #1;
        check_lit("rst_hi", HI, m_hi, 32'h0);
        check_lit("rst_lo", LO, m_lo, 32'h0);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        tick();
        Rst = 1'b1;
        tick();

        Start = 1'b1; ALUOp = OP_MTHI; A = 32'hDEAD; Cancel = 1'b1;
        tick();
        Start = 1'b0; Cancel = 1'b0;
        check_lit("start_cancel_hi", HI, m_hi, 32'h0);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] o;
            o = ops[$urandom_range(0, 12)];
            if (!is_valid(o)) begin
                Start = 1'b1; ALUOp = o; A = rnd32(); B = rnd32();
                repeat (2) tick();
                Start = 1'b0;
            end else begin
                issue(o, rnd32(), rnd32());
                if (is_mc(o) && $urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(0, 36)) tick();
                    cancel_pulse();
                end else if ($urandom_range(0, 1) == 0) begin
                    wait_idle();
                end
            end
        end
        wait_idle();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
